add_round_key: RTL and testbench
================================

Name: add_round_key

Overview:
- AES AddRoundKey stage: bitwise XOR of the 128-bit cipher state with a 128-bit round key.
- Two outputs from one XOR:
  - `new_state`: purely combinational.
  - `out_state`: a registered, valid/ready stream output.
- Sits between MixColumns (or ShiftRows in the final round) and the next round in the core datapath. Used for both encryption and decryption; AddRoundKey is its own inverse.

Parameters:
- `W`, 128, state/key width in bits; fixed at 128 for AES and must be a multiple of 8.
- `PIPE`, 1, 1 = registered stream path present; 0 = `out_*` is a combinational pass-through of `in_*`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `state`  in  W  input cipher state, byte 0 = bits [W-1:W-8] (AES column-major order).
- `round_key`  in  W  round key, same byte order.
- `new_state`  out  W  combinational `state ^ round_key`.
- `in_valid`  in  1  `state`/`round_key` valid for the stream path.
- `in_ready`  out  1  stage can accept.
- `out_valid`  out  1  `out_state` valid.
- `out_ready`  in  1  downstream accepts.
- `out_state`  out  W  registered XOR result.

Behaviour:
- `new_state = state ^ round_key` at all times.
  - Independent of `clk`/`rst`/`in_valid`; zero-cycle latency.
  - Settles within the same delta/timestep.
- Stream path (`PIPE=1`): one-deep pipeline register plus one-entry skid buffer, so `in_ready` is registered (no combinational `out_ready`→`in_ready` path).
  - Handshakes:
    - Input transfer when `in_valid && in_ready`.
    - Output transfer when `out_valid && out_ready`.
  - Latency: 1 cycle from input transfer to `out_valid`.
  - Throughput: 1 transfer/cycle when `out_ready` is held high.
  - States:
    - EMPTY: `out_valid=0`, `in_ready=1`.
    - FULL: main register valid, skid empty, `in_ready=1`.
    - SKID: both valid, `in_ready=0`.
  - Transitions:
    - EMPTY + in xfer → FULL.
    - FULL + in xfer + no out xfer → SKID.
    - FULL + out xfer + no in xfer → EMPTY.
    - FULL + in and out xfer → FULL with new data.
    - SKID + out xfer → FULL; the skid data moves to the main register.
  - Ordering: strict FIFO, no drop, no duplication.
  - `out_state` must hold stable while `out_valid && !out_ready`.
- Reset (synchronous, dominates all other events in the same cycle):
  - `out_valid=0`, `in_ready=1`, `out_state=0`, skid cleared.
  - Reset mid-operation discards all in-flight data.
- `in_valid` while `in_ready=0` has no effect; the source must hold its data.
- `out_ready` with `out_valid=0` has no effect.
- Width rule: pure XOR, no carries; every bit is independent.
- `PIPE=0`:
  - `out_state = new_state`, `out_valid = in_valid`, `in_ready = out_ready`.
  - No registers are used.

Decomposition:
- Package `aes_pkg`: `AES_W=128`, `typedef logic [127:0] aes_state_t`, `typedef logic [7:0] aes_byte_t`, and function `get_byte(state, idx)` for column-major byte indexing (used by the bench).
- Sub-module `ark_skid_buffer`: the generic valid/ready one-entry skid register, parameterised on width. `add_round_key` = XOR + `ark_skid_buffer`.

Test Plan:
- Combinational: `state=00112233445566778899AABBCCDDEEFF`, `round_key=0F0E0D0C0B0A09080706050403020100`, wait #1, no clock → `new_state=0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFFF`.
- Identity/self-inverse:
  - `round_key=0` → `new_state=state`.
  - `state=round_key=FFFF…FF` → `new_state=0`.
  - Applying the result with the same key returns the original state.
- Stream, `out_ready=1`, 4 back-to-back inputs with keys `i*0x0101…01` → 4 outputs on consecutive cycles, each 1 cycle after input, correct XORs, in order.
- Backpressure:
  - Hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready` drops after 2 accepted beats.
  - `out_state` stays stable.
  - On release, both beats emerge in order with none lost.
- Reset: assert `rst` for 1 cycle while in SKID state → next cycle `out_valid=0`, `in_ready=1`, `out_state=0`, and no stale beat ever appears.
- Random: 10k cycles of random `in_valid`/`out_ready` and data against a scoreboard FIFO → every output equals its input `state ^ round_key` in order; `new_state` checked every cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types and the column-major byte accessor.
// Also holds the state encoding for the one-entry skid register.
package aes_pkg;

  localparam int AES_W = 128;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_FULL  = 2'd1,
    SB_SKID  = 2'd2
  } skid_state_e;

  // Byte 0 is the most significant byte (AES column-major order).
  function automatic aes_byte_t get_byte(input aes_state_t s, input int unsigned idx);
    return 8'(s >> (8 * (15 - idx)));
  endfunction

endpackage

// File: rtl/ark_skid_buffer.sv
// Generic valid/ready stage with one main register and one skid entry.
// in_ready is decoded from the state flops only, so out_ready never reaches it combinationally.
//
// state    | meaning
// ---------+-----------------------------------------------
// SB_EMPTY | nothing held, out_valid=0, in_ready=1
// SB_FULL  | main register valid, skid empty, in_ready=1
// SB_SKID  | main and skid both valid, in_ready=0
module ark_skid_buffer
  import aes_pkg::*;
#(
  parameter int DW = AES_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_xfer;
  logic          out_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    case (state_q)
      SB_EMPTY: begin
        if (in_xfer) begin
          state_d = SB_FULL;
          main_d  = in_data;
        end
      end
      SB_FULL: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = SB_SKID;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = SB_EMPTY;
        end
      end
      SB_SKID: begin
        // Skid holds the younger beat; it moves up once the main beat leaves.
        if (out_xfer) begin
          state_d = SB_FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = SB_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != SB_SKID);
    out_valid = (state_q != SB_EMPTY);
    out_data  = main_q;
  end

endmodule

// File: rtl/add_round_key.sv
// AES AddRoundKey: state XOR round key, exposed both combinationally
// and through an optional registered valid/ready stream stage.
module add_round_key
  import aes_pkg::*;
#(
  parameter int W    = AES_W,
  parameter int PIPE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] state,
  input  logic [W-1:0] round_key,
  output logic [W-1:0] new_state,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_state
);

  assign new_state = state ^ round_key;

  if (PIPE != 0) begin : g_pipe
    ark_skid_buffer #(.DW(W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (new_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_state)
    );
  end else begin : g_bypass
    assign out_state = new_state;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
  end

endmodule

// File: tb/tb_add_round_key.sv
// Directed and randomised checks of add_round_key with a scoreboard FIFO.
module tb_add_round_key;
  import aes_pkg::*;

  logic         clk;
  logic         rst;
  logic [127:0] state;
  logic [127:0] round_key;
  logic [127:0] new_state;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_checks;
  int n_err;

  add_round_key #(.W(128), .PIPE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .round_key (round_key),
    .new_state (new_state),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] sb_q[$];
    logic [127:0] exp_v;
    logic [127:0] held_v;
    logic [127:0] beat_exp [4];
    logic         held;
    logic [7:0]   k8;

    n_checks  = 0;
    n_err     = 0;
    rst       = 1'b1;
    state     = '0;
    round_key = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_state", out_state, 128'd0);

    // Combinational XOR, no clock edge involved
    state     = 128'h00112233445566778899AABBCCDDEEFF;
    round_key = 128'h0F0E0D0C0B0A09080706050403020100;
    #1;
    check("comb_vec", new_state, 128'h0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFFF);
    check("get_byte0", 128'(get_byte(new_state, 0)), 128'h0F);
    check("get_byte15", 128'(get_byte(new_state, 15)), 128'hFF);
    round_key = '0;
    #1;
    check("key_zero", new_state, 128'h00112233445566778899AABBCCDDEEFF);
    state     = {16{8'hFF}};
    round_key = {16{8'hFF}};
    #1;
    check("all_ones", new_state, 128'd0);
    state     = 128'h0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFFF;
    round_key = 128'h0F0E0D0C0B0A09080706050403020100;
    #1;
    check("self_inverse", new_state, 128'h00112233445566778899AABBCCDDEEFF);

    // Back-to-back stream, state A5.. with keys i*0101..01
    beat_exp[0] = {16{8'hA4}};
    beat_exp[1] = {16{8'hA7}};
    beat_exp[2] = {16{8'hA6}};
    beat_exp[3] = {16{8'hA1}};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state     = {16{8'hA5}};
    for (int i = 0; i < 4; i++) begin
      k8        = 8'(i + 1);
      round_key = {16{k8}};
      #1;
      check("stream_in_ready", 128'(in_ready), 128'd1);
      step();
      check("stream_out_valid", 128'(out_valid), 128'd1);
      check("stream_out_state", out_state, beat_exp[i]);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", 128'(out_valid), 128'd0);

    // Backpressure: two beats fill main+skid, third waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state     = {16{8'h3C}};
    round_key = {16{8'h0F}};
    step();
    check("bp_ready_after1", 128'(in_ready), 128'd1);
    check("bp_state_after1", out_state, {16{8'h33}});
    state = {16{8'hC3}};
    step();
    check("bp_ready_after2", 128'(in_ready), 128'd0);
    check("bp_state_after2", out_state, {16{8'h33}});
    state     = {16{8'h55}};
    round_key = '0;
    step();
    check("bp_ready_after3", 128'(in_ready), 128'd0);
    check("bp_state_after3", out_state, {16{8'h33}});
    out_ready = 1'b1;
    step();
    check("bp_rel1_valid", 128'(out_valid), 128'd1);
    check("bp_rel1_state", out_state, {16{8'hCC}});
    check("bp_rel1_ready", 128'(in_ready), 128'd1);
    step();
    check("bp_rel2_state", out_state, {16{8'h55}});
    in_valid = 1'b0;
    step();
    check("bp_drained", 128'(out_valid), 128'd0);

    // Reset while in SKID discards both beats
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state     = {16{8'h12}};
    round_key = {16{8'h34}};
    step();
    step();
    check("skid_reached", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("rst_skid_out_valid", 128'(out_valid), 128'd0);
    check("rst_skid_in_ready", 128'(in_ready), 128'd1);
    check("rst_skid_out_state", out_state, 128'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_stale", 128'(out_valid), 128'd0);
    end

    // Random traffic against the scoreboard
    held   = 1'b0;
    held_v = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        state     = rand128();
        round_key = rand128();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd_new_state", new_state, state ^ round_key);
      if (held) begin
        check("rnd_hold_valid", 128'(out_valid), 128'd1);
        check("rnd_hold_state", out_state, held_v);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("rnd_spurious", 128'(out_valid), 128'd0);
        end else begin
          exp_v = sb_q.pop_front();
          check("rnd_out_state", out_state, exp_v);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(state ^ round_key);
      held   = out_valid && !out_ready;
      held_v = out_state;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("drain_spurious", 128'(out_valid), 128'd0);
        end else begin
          exp_v = sb_q.pop_front();
          check("drain_out_state", out_state, exp_v);
        end
      end
      step();
    end
    check("drain_empty", 128'(sb_q.size()), 128'd0);
    check("drain_out_valid", 128'(out_valid), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
